// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Sequential-PC instruction fetch with an in-order ring buffer
//            feeding decode; drops stale memory responses after a redirect.
// Revision : 1.0  initial release
// ============================================================================
module fetch #(
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter int unsigned         PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         BUF_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    pc_out
);

    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_DEPTH   = PTR_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]       alloc_q, alloc_d;
    logic [PTR_W-1:0]       fill_q, fill_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic [PC_WIDTH-1:0]    pc_buf_q    [BUF_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_buf_q [BUF_DEPTH];

    logic [PTR_W-1:0]       w_in_use;
    logic [PTR_W-1:0]       w_in_flight;
    logic [IDX_W-1:0]       w_head_idx;
    logic                   w_req_hs;
    logic                   w_pop;
    logic                   w_resp_accept;

    assign w_in_use    = alloc_q - head_q;
    assign w_in_flight = alloc_q - fill_q;
    assign w_head_idx  = head_q[IDX_W-1:0];

    assign imem_req_valid = (state_q == ST_RUN) && (w_in_use < c_DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = (fill_q != head_q);
    assign instr_out      = out_valid ? instr_buf_q[w_head_idx] : '0;
    assign pc_out         = out_valid ? pc_buf_q[w_head_idx] : '0;

    assign w_req_hs      = imem_req_valid && imem_req_ready;
    assign w_pop         = out_valid && out_ready && !redirect_valid;
    // Responses only land while nothing stale is outstanding and a slot awaits data.
    assign w_resp_accept = imem_resp_valid && !redirect_valid &&
                           (drop_cnt_q == '0) && (fill_q != alloc_q);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        drop_cnt_d = drop_cnt_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~PC_WIDTH'(3);
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            drop_cnt_d = drop_cnt_q + w_in_flight + PTR_W'(w_req_hs)
                         - PTR_W'(imem_resp_valid);
        end else begin
            if (w_req_hs) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
                alloc_d    = alloc_q + c_PTR_ONE;
            end
            if (w_resp_accept) begin
                fill_d = fill_q + c_PTR_ONE;
            end
            if (w_pop) begin
                head_d = head_q + c_PTR_ONE;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - c_PTR_ONE;
            end
        end

        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect_valid && (drop_cnt_d != '0)) state_d = ST_FLUSH;
            ST_FLUSH: if (drop_cnt_d == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_req_hs && !redirect_valid) begin
            pc_buf_q[alloc_q[IDX_W-1:0]] <= fetch_pc_q;
        end
        if (w_resp_accept) begin
            instr_buf_q[fill_q[IDX_W-1:0]] <= imem_resp_data;
        end
    end

    a_resp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((fill_q != alloc_q) || (drop_cnt_q != '0)));

endmodule
`default_nettype wire
